// File: rtl/isp_loader.sv
// Framed byte-stream program loader: writes 32-bit words into core program memory,
// verifies an XOR checksum over the frame body, then pulses start with the base address.
module isp_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    start,
  output logic [19:0]             prog_address,
  output logic                    busy,
  output logic                    load_ok,
  output logic                    load_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    SYNC     = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BASE0 = 3'd1,
    ST_BASE1 = 3'd2,
    ST_CNT0  = 3'd3,
    ST_CNT1  = 3'd4,
    ST_DATA  = 3'd5,
    ST_CSUM  = 3'd6,
    ST_START = 3'd7
  } state_t;

  state_t                  state_q;
  logic [ADDRESS_BITS-1:0] base_q;
  logic [15:0]             cnt_q;
  logic [15:0]             word_idx_q;
  logic [1:0]              byte_idx_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [7:0]              csum_q;
  logic [TW-1:0]           tmo_q;
  logic                    isp_write_q;
  logic [ADDRESS_BITS-1:0] isp_address_q;
  logic [DATA_WIDTH-1:0]   isp_data_q;
  logic                    start_q;
  logic [19:0]             prog_address_q;
  logic                    load_ok_q;
  logic                    load_err_q;
  logic                    accept_s;
  logic                    in_frame_s;

  assign rx_ready     = (state_q != ST_START);
  assign busy         = (state_q != ST_IDLE);
  assign accept_s     = rx_valid & rx_ready;
  assign in_frame_s   = (state_q != ST_IDLE) && (state_q != ST_START);
  assign isp_write    = isp_write_q;
  assign isp_address  = isp_address_q;
  assign isp_data     = isp_data_q;
  assign start        = start_q;
  assign prog_address = prog_address_q;
  assign load_ok      = load_ok_q;
  assign load_err     = load_err_q;

  // Frame-parsing FSM with registered strobes, sticky status and inter-byte timeout
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      cnt_q          <= 16'd0;
      word_idx_q     <= 16'd0;
      byte_idx_q     <= 2'd0;
      shift_q        <= '0;
      csum_q         <= 8'd0;
      tmo_q          <= '0;
      isp_write_q    <= 1'b0;
      isp_address_q  <= '0;
      isp_data_q     <= '0;
      start_q        <= 1'b0;
      prog_address_q <= 20'd0;
      load_ok_q      <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      isp_write_q <= 1'b0;
      start_q     <= 1'b0;
      if (accept_s || !in_frame_s) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
      // A stalled frame is abandoned; words already written stay in memory
      if (in_frame_s && !accept_s && (tmo_q == TMO_LAST)) begin
        state_q    <= ST_IDLE;
        load_err_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_s && (rx_data == SYNC)) begin
              state_q    <= ST_BASE0;
              csum_q     <= 8'd0;
              load_ok_q  <= 1'b0;
              load_err_q <= 1'b0;
            end
          end
          ST_BASE0: begin
            if (accept_s) begin
              base_q  <= ADDRESS_BITS'(rx_data);
              csum_q  <= csum_q ^ rx_data;
              state_q <= ST_BASE1;
            end
          end
          ST_BASE1: begin
            if (accept_s) begin
              base_q  <= ADDRESS_BITS'({rx_data, base_q[7:0]});
              csum_q  <= csum_q ^ rx_data;
              state_q <= ST_CNT0;
            end
          end
          ST_CNT0: begin
            if (accept_s) begin
              cnt_q   <= {8'd0, rx_data};
              csum_q  <= csum_q ^ rx_data;
              state_q <= ST_CNT1;
            end
          end
          ST_CNT1: begin
            if (accept_s) begin
              cnt_q      <= {rx_data, cnt_q[7:0]};
              csum_q     <= csum_q ^ rx_data;
              word_idx_q <= 16'd0;
              byte_idx_q <= 2'd0;
              state_q    <= ({rx_data, cnt_q[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
            end
          end
          ST_DATA: begin
            if (accept_s) begin
              csum_q     <= csum_q ^ rx_data;
              shift_q    <= {rx_data, shift_q[DATA_WIDTH-1:8]};
              byte_idx_q <= byte_idx_q + 2'd1;
              // Little-endian assembly: the fourth byte lands in the top lane
              if (byte_idx_q == 2'd3) begin
                isp_write_q   <= 1'b1;
                isp_data_q    <= {rx_data, shift_q[DATA_WIDTH-1:8]};
                isp_address_q <= base_q + word_idx_q[ADDRESS_BITS-1:0];
                word_idx_q    <= word_idx_q + 16'd1;
                if ((word_idx_q + 16'd1) == cnt_q) begin
                  state_q <= ST_CSUM;
                end
              end
            end
          end
          ST_CSUM: begin
            if (accept_s) begin
              if (rx_data == csum_q) begin
                state_q        <= ST_START;
                load_ok_q      <= 1'b1;
                start_q        <= 1'b1;
                prog_address_q <= 20'(base_q);
              end else begin
                state_q    <= ST_IDLE;
                load_err_q <= 1'b1;
              end
            end
          end
          ST_START: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
